// File: rtl/life_pkg.sv
// Shared types and helpers for the Game of Life generation sequencer.
package life_pkg;

    typedef enum logic [2:0] {
        ST_PAUSE = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_LOAD1 = 3'd3,
        ST_LOAD2 = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    localparam int unsigned GEN_W_DEF = 16;
    localparam int unsigned PAT_W_DEF = 2;

    // Generation period in Clk cycles: each speed step doubles the rate.
    function automatic int unsigned speed_period(input int unsigned base,
                                                 input logic [1:0]  sel);
        return base >> sel;
    endfunction

endpackage

// File: rtl/life_rate_div.sv
// Generation-rate divider: counts Clk cycles and flags when the selected
// period has elapsed.
module life_rate_div
    import life_pkg::*;
#(
    parameter int unsigned BASE_DIV = 50_000_000,
    parameter int unsigned DIV_W    = 26
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] speed_sel_i,
    input  logic       clear_i,
    input  logic       inc_i,
    output logic       expire_o
);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [DIV_W-1:0] period_m1;

    // >= rather than == so a mid-count speed increase fires next cycle
    // instead of wrapping the counter.
    always_comb begin
        period_m1 = DIV_W'(speed_period(BASE_DIV, speed_sel_i) - 32'd1);
        expire_o  = (div_cnt_q >= period_m1);
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clear_i) begin
            div_cnt_d = '0;
        end else if (inc_i) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/life_gen_controller.sv
// Generation sequencer: turns debounced buttons into the grid's advance
// strobe, reload pulse and pattern select; counts and auto-halts generations.
module life_gen_controller
    import life_pkg::*;
#(
    parameter int unsigned BASE_DIV = 50_000_000,
    parameter int unsigned DIV_W    = 26,
    parameter int unsigned GEN_W    = GEN_W_DEF,
    parameter int unsigned PAT_W    = PAT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [1:0]       speed_sel,
    input  logic             auto_halt,
    input  logic             all_dead,
    output logic             gen_tick,
    output logic             grid_load_n,
    output logic [PAT_W-1:0] pattern_sel,
    output logic [GEN_W-1:0] gen_count,
    output logic             running,
    output logic             halted
);

    state_t           state_q;
    logic             run_q;
    logic             step_q;
    logic             load_q;
    logic             gen_tick_q;
    logic             grid_load_n_q;
    logic [PAT_W-1:0] pattern_sel_q;
    logic [GEN_W-1:0] gen_count_q;
    logic             running_q;
    logic             halted_q;

    logic run_ev;
    logic step_ev;
    logic load_ev;
    logic halt_cond;
    logic run_active;
    logic div_inc;
    logic div_clear;
    logic expire;

    always_comb begin
        run_ev     = btn_run  & ~run_q;
        step_ev    = btn_step & ~step_q;
        load_ev    = btn_load & ~load_q;
        halt_cond  = auto_halt & all_dead;
        // Counting only continues while RUN is kept this cycle.
        run_active = (state_q == ST_RUN) && !load_ev && !run_ev && !halt_cond;
        div_inc    = run_active;
        div_clear  = (state_q == ST_LOAD1) || (run_active && expire);
    end

    life_rate_div #(
        .BASE_DIV (BASE_DIV),
        .DIV_W    (DIV_W)
    ) u_rate_div (
        .Clk         (Clk),
        .Rst         (Rst),
        .speed_sel_i (speed_sel),
        .clear_i     (div_clear),
        .inc_i       (div_inc),
        .expire_o    (expire)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= ST_PAUSE;
            run_q         <= 1'b0;
            step_q        <= 1'b0;
            load_q        <= 1'b0;
            gen_tick_q    <= 1'b0;
            grid_load_n_q <= 1'b1;
            pattern_sel_q <= '0;
            gen_count_q   <= '0;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            run_q         <= btn_run;
            step_q        <= btn_step;
            load_q        <= btn_load;
            gen_tick_q    <= 1'b0;
            grid_load_n_q <= 1'b1;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;

            case (state_q)
                ST_LOAD1: begin
                    state_q       <= ST_LOAD2;
                    grid_load_n_q <= 1'b0;
                    gen_count_q   <= '0;
                end
                ST_LOAD2: begin
                    state_q <= ST_PAUSE;
                end
                default: begin
                    if (load_ev) begin
                        state_q       <= ST_LOAD1;
                        pattern_sel_q <= pattern_in;
                    end else begin
                        case (state_q)
                            ST_PAUSE: begin
                                if (run_ev) begin
                                    state_q   <= ST_RUN;
                                    running_q <= 1'b1;
                                end else if (step_ev) begin
                                    state_q     <= ST_STEP;
                                    gen_tick_q  <= 1'b1;
                                    gen_count_q <= gen_count_q + GEN_W'(1);
                                end
                            end
                            ST_STEP: begin
                                state_q <= ST_PAUSE;
                            end
                            ST_RUN: begin
                                if (run_ev) begin
                                    state_q <= ST_PAUSE;
                                end else if (halt_cond) begin
                                    state_q  <= ST_HALT;
                                    halted_q <= 1'b1;
                                end else begin
                                    running_q <= 1'b1;
                                    if (expire) begin
                                        gen_tick_q  <= 1'b1;
                                        gen_count_q <= gen_count_q + GEN_W'(1);
                                    end
                                end
                            end
                            ST_HALT: begin
                                halted_q <= 1'b1;
                            end
                            default: begin
                                state_q <= ST_PAUSE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        gen_tick    = gen_tick_q;
        grid_load_n = grid_load_n_q;
        pattern_sel = pattern_sel_q;
        gen_count   = gen_count_q;
        running     = running_q;
        halted      = halted_q;
    end

endmodule

// File: tb/tb_life_gen_controller.sv
// Scoreboard bench for life_gen_controller with a short base period (8 cycles).
module tb_life_gen_controller;

    localparam int GEN_W = 16;
    localparam int PAT_W = 2;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             btn_run = 1'b0;
    logic             btn_step = 1'b0;
    logic             btn_load = 1'b0;
    logic [PAT_W-1:0] pattern_in = '0;
    logic [1:0]       speed_sel = '0;
    logic             auto_halt = 1'b0;
    logic             all_dead = 1'b0;
    logic             gen_tick;
    logic             grid_load_n;
    logic [PAT_W-1:0] pattern_sel;
    logic [GEN_W-1:0] gen_count;
    logic             running;
    logic             halted;

    typedef struct {
        bit is_load;
        int cyc;
        int cnt;
        int pat;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    life_gen_controller #(
        .BASE_DIV (8),
        .DIV_W    (4),
        .GEN_W    (GEN_W),
        .PAT_W    (PAT_W)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .btn_run     (btn_run),
        .btn_step    (btn_step),
        .btn_load    (btn_load),
        .pattern_in  (pattern_in),
        .speed_sel   (speed_sel),
        .auto_halt   (auto_halt),
        .all_dead    (all_dead),
        .gen_tick    (gen_tick),
        .grid_load_n (grid_load_n),
        .pattern_sel (pattern_sel),
        .gen_count   (gen_count),
        .running     (running),
        .halted      (halted)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_ev(input bit l, input int c, input int n, input int p);
        exp_t e;
        e.is_load = l;
        e.cyc     = c;
        e.cnt     = n;
        e.pat     = p;
        q.push_back(e);
    endfunction

    // Monitor: every tick or reload pulse must match the head of the scoreboard.
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Rst) begin
            if (gen_tick) check("tick_with_load_low", int'(grid_load_n), 1);
            if (gen_tick || !grid_load_n) begin
                if (q.size() == 0) begin
                    check("unexpected_event_cycle", cyc, -1);
                end else begin
                    e = q.pop_front();
                    check("event_is_load", int'(!grid_load_n), int'(e.is_load));
                    check("event_cycle", cyc, e.cyc);
                    check("event_gen_count", int'(gen_count), e.cnt);
                    if (e.is_load) check("event_pattern_sel", int'(pattern_sel), e.pat);
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // which: 0=run 1=step 2=load; ev is the edge at which the DUT sees the event.
    task automatic press(input int which, output int ev);
        @(posedge Clk);
        #1;
        case (which)
            0:       btn_run  = 1'b1;
            1:       btn_step = 1'b1;
            default: btn_load = 1'b1;
        endcase
        ev = cyc + 1;
        @(posedge Clk);
        #1;
        btn_run  = 1'b0;
        btn_step = 1'b0;
        btn_load = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int e;
        #1 Rst = 1'b0;
        #2;
        check("rst_gen_tick", int'(gen_tick), 0);
        check("rst_grid_load_n", int'(grid_load_n), 1);
        check("rst_pattern_sel", int'(pattern_sel), 0);
        check("rst_gen_count", int'(gen_count), 0);
        check("rst_running", int'(running), 0);
        check("rst_halted", int'(halted), 0);
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b1;

        // Free-running at base rate: a tick every 8 cycles.
        press(0, e);
        expect_ev(0, e + 8, 1, 0);
        expect_ev(0, e + 16, 2, 0);
        expect_ev(0, e + 24, 3, 0);
        check("run_running", int'(running), 1);
        wait_until(e + 26);

        // Load while running: pattern latched, one-cycle low pulse, count cleared.
        pattern_in = 2'd2;
        press(2, e);
        expect_ev(1, e + 1, 0, 2);
        check("load_pattern_sel", int'(pattern_sel), 2);
        check("load1_grid_load_n", int'(grid_load_n), 1);
        check("load1_running", int'(running), 0);
        wait_until(e + 2);
        check("load_done_grid_load_n", int'(grid_load_n), 1);
        check("load_done_gen_count", int'(gen_count), 0);

        // Single steps from PAUSE.
        for (int i = 1; i <= 3; i++) begin
            press(1, e);
            expect_ev(0, e, i, 0);
        end
        wait_until(e + 2);
        check("step_gen_count", int'(gen_count), 3);
        check("step_running", int'(running), 0);

        // Speed increase mid-count fires next cycle, then every 2 cycles.
        press(0, e);
        expect_ev(0, e + 7, 4, 0);
        expect_ev(0, e + 9, 5, 0);
        expect_ev(0, e + 11, 6, 0);
        wait_until(e + 6);
        speed_sel = 2'd2;
        wait_until(e + 11);
        press(0, e);
        check("pause_running", int'(running), 0);
        check("pause_gen_count", int'(gen_count), 6);
        speed_sel = 2'd0;

        // Auto-halt wins over a coincident expiry; HALT ignores run/step.
        auto_halt = 1'b1;
        press(0, e);
        wait_until(e + 6);
        all_dead = 1'b1;
        wait_until(e + 7);
        check("halt_halted", int'(halted), 1);
        check("halt_running", int'(running), 0);
        press(1, e);
        press(0, e);
        wait_until(e + 3);
        check("halt_hold_halted", int'(halted), 1);
        check("halt_hold_gen_count", int'(gen_count), 6);
        pattern_in = 2'd1;
        press(2, e);
        expect_ev(1, e + 1, 0, 1);
        wait_until(e + 2);
        check("halt_exit_halted", int'(halted), 0);
        check("halt_exit_running", int'(running), 0);
        check("halt_exit_pattern_sel", int'(pattern_sel), 1);
        all_dead  = 1'b0;
        auto_halt = 1'b0;

        // Asynchronous reset mid-run.
        press(1, e);
        expect_ev(0, e, 1, 0);
        press(0, e);
        expect_ev(0, e + 8, 2, 0);
        wait_until(e + 10);
        Rst = 1'b0;
        #1;
        check("arst_gen_count", int'(gen_count), 0);
        check("arst_pattern_sel", int'(pattern_sel), 0);
        check("arst_running", int'(running), 0);
        check("arst_grid_load_n", int'(grid_load_n), 1);
        check("arst_gen_tick", int'(gen_tick), 0);
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b1;
        press(0, e);
        expect_ev(0, e + 8, 1, 0);
        wait_until(e + 12);

        check("scoreboard_left", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
